arc4_encrypt: RTL and testbench

ARC4 encryptor: the writer-side counterpart of the cracking/decryption datapath. It takes a 24-bit key and a length-prefixed plaintext memory, then writes a length-prefixed ciphertext memory in exactly the format the `ct` RAM of the cracker consumes. It drives an external 256×8 S-box RAM, reads a `pt` RAM and writes a `ct` RAM, all single-port altsyncram instances with registered address. It is used to generate on-chip test ciphertexts and as a hardware reference for the decryption path.

---
 rtl/arc4_pkg.sv | 24 ++
 rtl/arc4_encrypt_if.sv | 45 ++++
 rtl/arc4_encrypt.sv | 203 ++++++++++++++++++++
 tb/tb_arc4_encrypt.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions for the encryptor and the cracker/decryptor datapaths.
package arc4_pkg;

    localparam int ARC4_N       = 256;
    localparam int ARC4_KEY_MAX = 16;
    localparam int ARC4_KEY_W   = 8 * ARC4_KEY_MAX;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_KSA  = 2'd2,
        ST_PRGA = 2'd3
    } state_t;

    // Byte n of an nbytes-long big-endian key held right-aligned in key.
    function automatic byte_t key_byte(input logic [ARC4_KEY_W-1:0] key,
                                       input int unsigned nbytes,
                                       input int unsigned n);
        return byte_t'(key >> (32'd8 * (nbytes - 32'd1 - n)));
    endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Handshake plus S-box / pt / ct RAM ports of arc4_encrypt.
// The keystream tap signals exist only when ARC4_ENC_KS_OUT_EN is defined.
interface arc4_encrypt_if #(
    parameter int KEY_BYTES = 3
);
    import arc4_pkg::*;

    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    byte_t                  s_addr;
    byte_t                  s_wrdata;
    logic                   s_wren;
    byte_t                  s_rddata;
    byte_t                  pt_addr;
    byte_t                  pt_rddata;
    byte_t                  ct_addr;
    byte_t                  ct_wrdata;
    logic                   ct_wren;
`ifdef ARC4_ENC_KS_OUT_EN
    logic                   ks_valid;
    byte_t                  ks_byte;

    modport master (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren,
        input  ks_valid, ks_byte
    );
    modport slave (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren,
        output ks_valid, ks_byte
    );
`else
    modport master (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );
    modport slave (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
    );
`endif

endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: key schedule on an external S-box RAM, then length-prefixed pt -> ct.
// Optional keystream tap (ks_valid/ks_byte) is built when ARC4_ENC_KS_OUT_EN is defined.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    arc4_encrypt_if.slave bus
);

    localparam byte_t KIDX_LAST = byte_t'(KEY_BYTES - 1);
    localparam byte_t S_LAST    = byte_t'(ARC4_N - 1);

    state_t                 state_q;
    logic [3:0]             ph_q;
    logic [8*KEY_BYTES-1:0] key_q;
    byte_t                  i_q, j_q, k_q, len_q, kidx_q, si_q, sj_q, pt_q;
    logic                   rdy_q, s_wren_q, ct_wren_q;
    byte_t                  s_addr_q, s_wrdata_q, pt_addr_q, ct_addr_q, ct_wrdata_q;
`ifdef ARC4_ENC_KS_OUT_EN
    logic                   ks_valid_q;
    byte_t                  ks_byte_q;
`endif

    logic [ARC4_KEY_W-1:0]  key_ext_s;
    byte_t                  i_inc_s, ksa_j_s, prga_j_s;

    assign key_ext_s = ARC4_KEY_W'(key_q);
    assign i_inc_s   = i_q + 8'd1;
    assign ksa_j_s   = j_q + bus.s_rddata + key_byte(key_ext_s, KEY_BYTES, 32'(kidx_q));
    assign prga_j_s  = j_q + bus.s_rddata;

    // Control FSM and datapath; RAM reads are captured two edges after the address is
    // registered, and the second swap write is suppressed when i equals j.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ph_q        <= 4'd0;
            key_q       <= '0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            kidx_q      <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            pt_q        <= 8'd0;
            rdy_q       <= 1'b1;
            s_wren_q    <= 1'b0;
            ct_wren_q   <= 1'b0;
            s_addr_q    <= 8'd0;
            s_wrdata_q  <= 8'd0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
`ifdef ARC4_ENC_KS_OUT_EN
            ks_valid_q  <= 1'b0;
            ks_byte_q   <= 8'd0;
`endif
        end else begin
            s_wren_q  <= 1'b0;
            ct_wren_q <= 1'b0;
`ifdef ARC4_ENC_KS_OUT_EN
            ks_valid_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        key_q   <= bus.key;
                        rdy_q   <= 1'b0;
                        i_q     <= 8'd0;
                        state_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    s_addr_q   <= i_q;
                    s_wrdata_q <= i_q;
                    s_wren_q   <= 1'b1;
                    i_q        <= i_inc_s;
                    if (i_q == S_LAST) begin
                        state_q <= ST_KSA;
                        ph_q    <= 4'd0;
                        j_q     <= 8'd0;
                        kidx_q  <= 8'd0;
                    end
                end
                ST_KSA: begin
                    ph_q <= ph_q + 4'd1;
                    case (ph_q)
                        4'd0: s_addr_q <= i_q;
                        4'd2: begin
                            si_q     <= bus.s_rddata;
                            j_q      <= ksa_j_s;
                            s_addr_q <= ksa_j_s;
                        end
                        4'd4: begin
                            s_addr_q   <= i_q;
                            s_wrdata_q <= bus.s_rddata;
                            s_wren_q   <= 1'b1;
                        end
                        4'd5: begin
                            s_addr_q   <= j_q;
                            s_wrdata_q <= si_q;
                            s_wren_q   <= (i_q != j_q);
                            ph_q       <= 4'd0;
                            i_q        <= i_inc_s;
                            kidx_q     <= (kidx_q == KIDX_LAST) ? 8'd0 : kidx_q + 8'd1;
                            if (i_q == S_LAST) begin
                                state_q <= ST_PRGA;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_PRGA: begin
                    ph_q <= ph_q + 4'd1;
                    // Phases 0-2 copy the length byte, 3-11 produce one data byte, 12 finishes.
                    case (ph_q)
                        4'd0: begin
                            pt_addr_q <= 8'd0;
                            i_q       <= 8'd0;
                            j_q       <= 8'd0;
                        end
                        4'd2: begin
                            len_q       <= bus.pt_rddata;
                            k_q         <= 8'd1;
                            ct_addr_q   <= 8'd0;
                            ct_wrdata_q <= bus.pt_rddata;
                            ct_wren_q   <= 1'b1;
                            if (bus.pt_rddata == 8'd0) begin
                                ph_q <= 4'd12;
                            end
                        end
                        4'd3: begin
                            i_q       <= i_inc_s;
                            s_addr_q  <= i_inc_s;
                            pt_addr_q <= k_q;
                        end
                        4'd5: begin
                            si_q     <= bus.s_rddata;
                            pt_q     <= bus.pt_rddata;
                            j_q      <= prga_j_s;
                            s_addr_q <= prga_j_s;
                        end
                        4'd7: begin
                            sj_q       <= bus.s_rddata;
                            s_addr_q   <= i_q;
                            s_wrdata_q <= bus.s_rddata;
                            s_wren_q   <= 1'b1;
                        end
                        4'd8: begin
                            s_addr_q   <= j_q;
                            s_wrdata_q <= si_q;
                            s_wren_q   <= (i_q != j_q);
                        end
                        4'd9: s_addr_q <= si_q + sj_q;
                        4'd11: begin
                            ct_addr_q   <= k_q;
                            ct_wrdata_q <= pt_q ^ bus.s_rddata;
                            ct_wren_q   <= 1'b1;
`ifdef ARC4_ENC_KS_OUT_EN
                            ks_valid_q  <= 1'b1;
                            ks_byte_q   <= bus.s_rddata;
`endif
                            if (k_q == len_q) begin
                                ph_q <= 4'd12;
                            end else begin
                                k_q  <= k_q + 8'd1;
                                ph_q <= 4'd3;
                            end
                        end
                        4'd12: begin
                            rdy_q   <= 1'b1;
                            ph_q    <= 4'd0;
                            state_q <= ST_IDLE;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.ct_wrdata = ct_wrdata_q;
    assign bus.ct_wren   = ct_wren_q;
`ifdef ARC4_ENC_KS_OUT_EN
    assign bus.ks_valid  = ks_valid_q;
    assign bus.ks_byte   = ks_byte_q;
`endif

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt with S-box/pt/ct RAM models and known-answer vectors.
module tb_arc4_encrypt;
    import arc4_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    arc4_encrypt_if #(.KEY_BYTES(3)) bus ();
    arc4_encrypt #(.KEY_BYTES(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    byte_t s_mem  [256];
    byte_t pt_mem [256];
    byte_t ct_mem [256];
    byte_t exp_ks [256];
    byte_t s_rd_q, pt_rd_q;
    int    ct_wr_cnt = 0;
    int    n_checks  = 0;
    int    n_pass    = 0;
    int    n_fail    = 0;

    assign bus.s_rddata  = s_rd_q;
    assign bus.pt_rddata = pt_rd_q;

    // Single-port RAM models with registered address and one-cycle read latency.
    always @(posedge clk) begin
        if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
        s_rd_q  <= s_mem[bus.s_addr];
        pt_rd_q <= pt_mem[bus.pt_addr];
        if (bus.ct_wren) begin
            ct_mem[bus.ct_addr] <= bus.ct_wrdata;
            ct_wr_cnt           <= ct_wr_cnt + 1;
        end
    end

`ifdef ARC4_ENC_KS_OUT_EN
    byte_t ks_log [512];
    int    ks_cnt = 0;
    int    ks_bad = 0;

    // Keystream tap log; a pulse must line up with every data-byte ct write and nothing else.
    always @(posedge clk) begin
        if (bus.ks_valid) begin
            ks_log[ks_cnt[8:0]] <= bus.ks_byte;
            ks_cnt              <= ks_cnt + 1;
        end
        if (bus.ks_valid != (bus.ct_wren && (bus.ct_addr != 8'd0))) ks_bad <= ks_bad + 1;
    end

    function automatic logic [71:0] ks_vec();
        logic [71:0] v = '0;
        for (int k = 0; k < 9; k++) v = {v[63:0], ks_log[k]};
        return v;
    endfunction
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] ct_vec();
        logic [79:0] v = '0;
        for (int k = 0; k < 10; k++) v = {v[71:0], ct_mem[k]};
        return v;
    endfunction

    task automatic load_plaintext();
        string s = "Plaintext";
        pt_mem[0] = 8'd9;
        for (int k = 0; k < 9; k++) pt_mem[k + 1] = s[k];
    endtask

    // Textbook ARC4 keystream for a 3-byte big-endian key; exp_ks[k] is byte k (k >= 1).
    task automatic rc4_model(input logic [23:0] key, input int len);
        byte_t S [256];
        byte_t t;
        int    i;
        int    j;
        for (int a = 0; a < 256; a++) S[a] = 8'(a);
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + int'(S[a]) + int'(8'(key >> (8 * (2 - a % 3))))) % 256;
            t = S[a]; S[a] = S[j]; S[j] = t;
        end
        i = 0;
        j = 0;
        for (int k = 1; k <= len; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(S[i])) % 256;
            t = S[i]; S[i] = S[j]; S[j] = t;
            exp_ks[k] = S[(int'(S[i]) + int'(S[j])) % 256];
        end
    endtask

    task automatic check_model(input string tag, input logic [23:0] key, input int len);
        int bad = 0;
        rc4_model(key, len);
        if (ct_mem[0] !== 8'(len)) bad++;
        for (int k = 1; k <= len; k++) begin
            if (ct_mem[k] !== (pt_mem[k] ^ exp_ks[k])) bad++;
        end
        chk(tag, 128'(bad), 128'(0));
    endtask

    task automatic start_job(input logic [23:0] key);
        @(negedge clk);
        bus.key = key;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        bus.key = 24'hA5C3E1;
    endtask

    task automatic wait_done(input string tag, input int len);
        int cyc   = 1;
        int bound = 1800 + 9 * len;
        while (!bus.rdy && cyc < bound + 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " rdy"}, 128'(bus.rdy), 128'(1));
        chk({tag, " cycles"}, 128'(cyc <= bound), 128'(1));
    endtask

    initial begin
        int c0;
        bus.en  = 1'b0;
        bus.key = 24'h0;
        load_plaintext();

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rdy", 128'(bus.rdy), 128'(1));
        chk("reset s_wren", 128'(bus.s_wren), 128'(0));
        chk("reset ct_wren", 128'(bus.ct_wren), 128'(0));
        chk("reset addrs", 128'({bus.s_addr, bus.pt_addr, bus.ct_addr}), 128'(0));
        chk("reset wrdata", 128'({bus.s_wrdata, bus.ct_wrdata}), 128'(0));
`ifdef ARC4_ENC_KS_OUT_EN
        chk("reset ks_valid", 128'(bus.ks_valid), 128'(0));
`endif
        rst_n = 1'b1;

        // Known answer: key "Key", plaintext "Plaintext".
        c0 = ct_wr_cnt;
        start_job(24'h4B6579);
        wait_done("key vec", 9);
        chk("key vec ct", 128'(ct_vec()), 128'(80'h09BBF316E8D940AF0AD3));
        chk("key vec writes", 128'(ct_wr_cnt - c0), 128'(10));
`ifdef ARC4_ENC_KS_OUT_EN
        chk("ks count", 128'(ks_cnt), 128'(9));
        chk("ks bytes", 128'(ks_vec()), 128'(72'hEB9F7781B734CA72A7));
`endif

        // Empty message: only the length byte is written.
        pt_mem[0] = 8'd0;
        c0 = ct_wr_cnt;
        start_job(24'h123456);
        wait_done("len0", 0);
        chk("len0 writes", 128'(ct_wr_cnt - c0), 128'(1));
        chk("len0 ct0", 128'(ct_mem[0]), 128'(0));

        // Full-length message, decrypted by the reference model.
        pt_mem[0] = 8'd255;
        for (int k = 1; k < 256; k++) pt_mem[k] = 8'(k * 37 + 11);
        c0 = ct_wr_cnt;
        start_job(24'h000018);
        wait_done("len255", 255);
        chk("len255 writes", 128'(ct_wr_cnt - c0), 128'(256));
        check_model("len255 decrypt", 24'h000018, 255);

        // Asynchronous reset in the middle of KSA, then a fresh known-answer run.
        load_plaintext();
        start_job(24'h4B6579);
        repeat (300) @(negedge clk);
        for (int n = 0; n < 8 && !bus.s_wren; n++) @(negedge clk);
        chk("ksa writing", 128'(bus.s_wren), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async rst s_wren", 128'(bus.s_wren), 128'(0));
        chk("async rst rdy", 128'(bus.rdy), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        start_job(24'h4B6579);
        wait_done("after rst", 9);
        chk("after rst ct", 128'(ct_vec()), 128'(80'h09BBF316E8D940AF0AD3));

        // en with another key while busy in PRGA must be ignored.
        start_job(24'h000018);
        for (int n = 0; n < 2000 && !bus.ct_wren; n++) @(negedge clk);
        chk("prga reached", 128'(bus.ct_wren), 128'(1));
        bus.key = 24'h4B6579;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        wait_done("busy en", 9);
        check_model("busy en ignored", 24'h000018, 9);
        repeat (5) @(negedge clk);
        chk("no restart", 128'(bus.rdy), 128'(1));
`ifdef ARC4_ENC_KS_OUT_EN
        chk("ks align", 128'(ks_bad), 128'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
